// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: merges CPU direct LED writes with autonomous
// static/blink/rotate/bounce steps onto the LED register write port.
module led_pattern_sequencer #(
  parameter logic [31:0] CFG_BASE = 32'h0000_8100,
  parameter logic [31:0] LED_ADDR = 32'h0000_8000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        led_we_o,
  output logic [3:0]  led_be_o,
  output logic [31:0] led_wdata_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [31:0] A_CTRL = CFG_BASE;
  localparam logic [31:0] A_PER  = CFG_BASE + 32'd4;
  localparam logic [31:0] A_PAT  = CFG_BASE + 32'd8;
  localparam logic [31:0] A_STAT = CFG_BASE + 32'd12;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [15:0]       pcfg_q, pcfg_d;
  logic [15:0]       pat_q, pat_d;
  logic [15:0]       frame_q, frame_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              phase_q, phase_d;
  logic              pend_q, pend_d;
  logic              blank_q, blank_d;
  logic              led_we_q, led_we_d;
  logic [3:0]        led_be_q, led_be_d;
  logic [31:0]       led_wdata_q, led_wdata_d;

  logic              en;
  logic [1:0]        mode;
  logic              wr_full;
  logic              led_hit;
  logic [CNT_W-1:0]  per_eff;
  logic              last;
  logic [15:0]       step_frame;
  logic              step_dir;
  logic              step_phase;
  logic              emit_fire;
  logic [15:0]       emit_frame;

  assign en      = ctrl_q[0];
  assign mode    = ctrl_q[2:1];
  assign wr_full = cpu_we && (cpu_be == 4'b1111);
  assign led_hit = cpu_we && (cpu_addr == LED_ADDR);
  assign per_eff = (per_q == '0) ? ONE : per_q;
  assign last    = (cnt_q >= per_eff - ONE);

  always_comb begin
    step_frame = frame_q;
    step_dir   = dir_q;
    step_phase = phase_q;
    unique case (mode)
      2'b00: step_frame = frame_q;
      2'b01: begin
        step_phase = ~phase_q;
        step_frame = phase_q ? 16'h0000 : pat_q;
      end
      2'b10: step_frame = {frame_q[14:0], frame_q[15]};
      2'b11: begin
        if (!dir_q && frame_q[15]) begin
          step_dir   = 1'b1;
          step_frame = frame_q >> 1;
        end else if (dir_q && frame_q[0]) begin
          step_dir   = 1'b0;
          step_frame = frame_q << 1;
        end else begin
          step_frame = dir_q ? (frame_q >> 1) : (frame_q << 1);
        end
      end
      default: step_frame = frame_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    per_d       = per_q;
    pcfg_d      = pcfg_q;
    pat_d       = pat_q;
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    blank_d     = blank_q;
    led_we_d    = 1'b0;
    led_be_d    = led_be_q;
    led_wdata_d = led_wdata_q;
    emit_fire   = 1'b0;
    emit_frame  = frame_q;

    if (wr_full) begin
      if (cpu_addr == A_CTRL) ctrl_d = cpu_wdata[2:0];
      if (cpu_addr == A_PER)  per_d  = cpu_wdata[CNT_W-1:0];
      if (cpu_addr == A_PAT)  pcfg_d = cpu_wdata[15:0];
    end

    unique case (state_q)
      S_IDLE: if (en) state_d = S_LOAD;
      S_LOAD: begin
        pat_d   = pcfg_q;
        frame_d = pcfg_q;
        cnt_d   = '0;
        dir_d   = 1'b0;
        phase_d = 1'b1;
        blank_d = 1'b0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (led_hit) begin
          pend_d = 1'b1;
        end else begin
          emit_fire = 1'b1;
          pend_d    = 1'b0;
          cnt_d     = '0;
          if (blank_q || !en) begin
            emit_frame = 16'h0000;
            frame_d    = 16'h0000;
            blank_d    = 1'b0;
            state_d    = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!en) begin
          frame_d = 16'h0000;
          blank_d = 1'b1;
          cnt_d   = '0;
          state_d = S_EMIT;
        end else if (last) begin
          frame_d = step_frame;
          dir_d   = step_dir;
          phase_d = step_phase;
          cnt_d   = '0;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU direct writes own the port; a colliding step write waits in EMIT
    if (led_hit) begin
      led_we_d    = 1'b1;
      led_be_d    = cpu_be;
      led_wdata_d = cpu_wdata;
    end else if (emit_fire) begin
      led_we_d    = 1'b1;
      led_be_d    = 4'b0011;
      led_wdata_d = {16'h0000, emit_frame};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      per_q       <= '0;
      pcfg_q      <= '0;
      pat_q       <= '0;
      frame_q     <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      phase_q     <= 1'b1;
      pend_q      <= 1'b0;
      blank_q     <= 1'b0;
      led_we_q    <= 1'b0;
      led_be_q    <= '0;
      led_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      per_q       <= per_d;
      pcfg_q      <= pcfg_d;
      pat_q       <= pat_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      blank_q     <= blank_d;
      led_we_q    <= led_we_d;
      led_be_q    <= led_be_d;
      led_wdata_q <= led_wdata_d;
    end
  end

  always_comb begin
    cpu_rdata = 32'h0;
    if (cpu_addr == A_CTRL) cpu_rdata = {29'h0, ctrl_q};
    if (cpu_addr == A_PER)  cpu_rdata = {{(32-CNT_W){1'b0}}, per_q};
    if (cpu_addr == A_PAT)  cpu_rdata = {16'h0, pcfg_q};
    if (cpu_addr == A_STAT) begin
      cpu_rdata = {27'h0, dir_q, pend_q, state_q, en};
    end
  end

  assign led_we_o    = led_we_q;
  assign led_be_o    = led_be_q;
  assign led_wdata_o = led_wdata_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: expected LED writes are
// queued from a frame-sequence model, a monitor pops them as writes appear.
module tb_led_pattern_sequencer;

  localparam logic [31:0] LED  = 32'h0000_8000;
  localparam logic [31:0] CTRL = 32'h0000_8100;
  localparam logic [31:0] PER  = 32'h0000_8104;
  localparam logic [31:0] PAT  = 32'h0000_8108;
  localparam logic [31:0] STAT = 32'h0000_810C;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] cpu_addr = 0;
  logic [31:0] cpu_wdata = 0;
  logic        cpu_we = 0;
  logic [3:0]  cpu_be = 0;
  logic [31:0] cpu_rdata;
  logic        led_we_o;
  logic [3:0]  led_be_o;
  logic [31:0] led_wdata_o;
  logic        busy_o;

  led_pattern_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_rdata(cpu_rdata),
    .led_we_o(led_we_o), .led_be_o(led_be_o),
    .led_wdata_o(led_wdata_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: one pop per observed write pulse
  always @(posedge clk) begin
    #1;
    cyc++;
    if (led_we_o) begin
      int g;
      exp_t e;
      g = cyc - last_cyc;
      last_cyc = cyc;
      if (q.size() == 0) begin
        chk("unexpected_write", led_wdata_o, 32'hxxxx_xxxx);
      end else begin
        e = q.pop_front();
        chk("led_wdata", led_wdata_o, e.data);
        chk("led_be", {28'h0, led_be_o}, {28'h0, e.be});
        if (e.gap > 0) chk("write_gap", g, e.gap);
      end
    end
  end

  task automatic cpu_wr(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_be = be; cpu_we = 1;
    @(negedge clk);
    cpu_we = 0;
  endtask

  task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
    @(negedge clk);
    cpu_we = 0; cpu_addr = a;
    #1 chk(name, cpu_rdata, exp);
  endtask

  task automatic wait_q(int sz);
    int t = 0;
    while (q.size() > sz && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > sz) begin
      chk("timeout_wait_writes", q.size(), sz);
      q.delete();
    end
  endtask

  function automatic logic [15:0] rotl(logic [15:0] p, int s);
    logic [31:0] x;
    x = {p, p} << (s % 16);
    return x[31:16];
  endfunction

  task automatic run(logic [1:0] mode, logic [15:0] pat,
                     logic [23:0] per, int n, bit collide);
    logic [15:0] fr[$];
    logic        dr[$];
    logic [15:0] f;
    logic        d;
    logic        ph;
    int          pe;
    exp_t        e;
    pe = (per == 0) ? 1 : int'(per);
    f = pat; d = 0; ph = 1;
    for (int i = 0; i < n; i++) begin
      fr.push_back(f);
      dr.push_back(d);
      case (mode)
        2'd0: f = pat;
        2'd1: begin ph = ~ph; f = ph ? pat : 16'h0; end
        2'd2: f = rotl(pat, i + 1);
        default: begin
          if (!d && f[15]) begin d = 1; f = f >> 1; end
          else if (d && f[0]) begin d = 0; f = f << 1; end
          else f = d ? (f >> 1) : (f << 1);
        end
      endcase
    end
    cpu_wr(PAT, {16'hDEAD, pat}, 4'hF);
    cpu_wr(PER, {8'h0, per}, 4'hF);
    cpu_wr(PER, 32'h55, 4'b0011);
    rd("pattern_rb", PAT, {16'h0, pat});
    rd("period_rb", PER, {8'h0, per});
    for (int i = 0; i < n; i++) begin
      e.data = {16'h0, fr[i]}; e.be = 4'b0011;
      e.gap = (i == 0) ? 0 : ((collide && i == 1) ? 1 : pe + 1);
      q.push_back(e);
      if (collide && i == 0) begin
        e.data = 32'h0000_ABCD; e.be = 4'b0011; e.gap = 0;
        q.push_back(e);
      end
    end
    e.data = 0; e.be = 4'b0011; e.gap = 0;
    q.push_back(e);
    cpu_wr(CTRL, {29'h0, mode, 1'b1}, 4'hF);
    if (collide) begin
      wait_q(q.size() - 1);
      repeat (pe) @(negedge clk);
      cpu_addr = LED; cpu_wdata = 32'h0000_ABCD; cpu_be = 4'b0011; cpu_we = 1;
      @(negedge clk);
      cpu_we = 0; cpu_addr = STAT;
      #1 chk("status_pend", cpu_rdata, {27'h0, dr[1], 1'b1, 2'b10, 1'b1});
      @(negedge clk);
      #1 chk("status_pend_clr", cpu_rdata, {27'h0, dr[1], 1'b0, 2'b11, 1'b1});
    end
    wait_q(1);
    cpu_addr = STAT;
    #1 chk("status_run_dir", cpu_rdata, {27'h0, dr[n-1], 4'b0111});
    cpu_addr = CTRL; cpu_wdata = 0; cpu_be = 4'hF; cpu_we = 1;
    @(negedge clk);
    cpu_we = 0;
    wait_q(0);
    repeat (3) @(negedge clk);
    chk("busy_after_disable", {31'h0, busy_o}, 32'h0);
    cpu_addr = STAT;
    #1 chk("status_idle", cpu_rdata & 32'hF, 32'h0);
  endtask

  initial begin
    // reset held while the CPU keeps writing
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_addr = (i == 1) ? LED : CTRL;
      cpu_wdata = 32'h1; cpu_be = 4'hF; cpu_we = (i != 2);
      #1 chk("rst_led_we", {31'h0, led_we_o}, 32'h0);
      chk("rst_busy", {31'h0, busy_o}, 32'h0);
    end
    @(negedge clk);
    cpu_we = 0;
    rst_n = 1;
    rd("rst_status", STAT, 32'h0);
    rd("rst_ctrl", CTRL, 32'h0);
    rd("rst_pattern", PAT, 32'h0);
    chk("rst_led_wdata", led_wdata_o, 32'h0);
    chk("rst_led_be", {28'h0, led_be_o}, 32'h0);
    rd("unmapped_rd", 32'h0000_8110, 32'h0);

    run(2'd2, 16'h8001, 24'd4, 3, 0);
    run(2'd1, 16'h00FF, 24'd0, 4, 0);
    run(2'd3, 16'h4000, 24'd1, 4, 0);
    run(2'd2, 16'h8001, 24'd4, 4, 1);
    run(2'd0, 16'h1234, 24'd2, 3, 0);

    for (int r = 0; r < 8; r++) begin
      run(2'($urandom_range(0, 3)), 16'($urandom),
          24'($urandom_range(0, 4)), $urandom_range(3, 8),
          bit'($urandom_range(0, 1)));
    end

    // reset mid-run must not emit a blanking write
    begin
      exp_t e;
      cpu_wr(PAT, 32'h0000_0F0F, 4'hF);
      cpu_wr(PER, 32'd4, 4'hF);
      e.data = 32'h0F0F; e.be = 4'b0011; e.gap = 0;
      q.push_back(e);
      e.data = 32'h1E1E; e.gap = 5;
      q.push_back(e);
      cpu_wr(CTRL, 32'd5, 4'hF);
      wait_q(0);
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      chk("midrst_busy", {31'h0, busy_o}, 32'h0);
      chk("midrst_wdata", led_wdata_o, 32'h0);
      rd("midrst_status", STAT, 32'h0);
      rd("midrst_period", PER, 32'h0);
      repeat (10) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
